conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 144 ++++++++++++++
 tb/tb_conv_window_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3 convolution window generator: two line buffers plus a 3x3 shift window.
// Define CONV_WINDOW_FLAGS_EN to add the win_eol / win_eof outputs.
module conv_window_gen #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic [DATA_W-1:0] tap1,
    output logic [DATA_W-1:0] tap2,
    output logic [DATA_W-1:0] tap3,
    output logic [DATA_W-1:0] tap4,
    output logic [DATA_W-1:0] tap5,
    output logic [DATA_W-1:0] tap6,
    output logic [DATA_W-1:0] tap7,
    output logic [DATA_W-1:0] tap8,
    output logic [DATA_W-1:0] tap9,
    output logic              win_valid,
    input  logic              win_ready
`ifdef CONV_WINDOW_FLAGS_EN
    ,
    output logic              win_eol,
    output logic              win_eof
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Position the next accepted pixel will take unless it carries sof.
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_win_valid;
    logic [DATA_W-1:0] r_tap [9];
    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];

    logic              w_accept;
    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_window;
    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;

    assign pix_ready = !r_win_valid || win_ready;
    assign w_accept  = pix_valid && pix_ready && !reset;

    // An sof pixel is (0,0) no matter where the counters currently point.
    assign w_col      = pix_sof ? '0 : r_col;
    assign w_row      = pix_sof ? '0 : r_row;
    assign w_col_last = (w_col == COL_LAST);
    assign w_row_last = (w_row == ROW_LAST);
    assign w_window   = (w_row >= ROW_TWO) && (w_col >= COL_TWO);

    assign w_lb0_rd = r_lb0[w_col];
    assign w_lb1_rd = r_lb1[w_col];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
        end
    end

    // NOTE: line buffers carry no reset; the row>=2 gate keeps stale rows out of any valid window.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_col] <= w_lb0_rd;
            r_lb0[w_col] <= pix_in;
        end
    end

    // Window shifts on every accept, including those that do not complete a window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_valid <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_tap[i] <= '0;
            end
        end else if (w_accept) begin
            r_win_valid <= w_window;
            for (int r = 0; r < 3; r++) begin
                r_tap[3*r]   <= r_tap[3*r+1];
                r_tap[3*r+1] <= r_tap[3*r+2];
            end
            r_tap[2] <= w_lb1_rd;
            r_tap[5] <= w_lb0_rd;
            r_tap[8] <= pix_in;
        end else if (win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

`ifdef CONV_WINDOW_FLAGS_EN
    logic r_eol;
    logic r_eof;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_eol <= 1'b0;
            r_eof <= 1'b0;
        end else if (w_accept) begin
            r_eol <= w_col_last;
            r_eof <= w_col_last && w_row_last;
        end
    end

    assign win_eol = r_eol;
    assign win_eof = r_eof;
`endif

    assign win_valid = r_win_valid;
    assign tap1      = r_tap[0];
    assign tap2      = r_tap[1];
    assign tap3      = r_tap[2];
    assign tap4      = r_tap[3];
    assign tap5      = r_tap[4];
    assign tap6      = r_tap[5];
    assign tap7      = r_tap[6];
    assign tap8      = r_tap[7];
    assign tap9      = r_tap[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen (4x4 image); an image-array model predicts every window.
// Flag outputs are checked when CONV_WINDOW_FLAGS_EN is defined.
module tb_conv_window_gen;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int DW    = 16;

    typedef logic [8:0][DW-1:0] taps_t;
    typedef struct packed {
        taps_t t;
        logic  eol;
        logic  eof;
    } win_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic [DW-1:0] tap1, tap2, tap3, tap4, tap5, tap6, tap7, tap8, tap9;
    logic          win_valid;
    logic          win_ready = 1'b1;
`ifdef CONV_WINDOW_FLAGS_EN
    logic          win_eol;
    logic          win_eof;
`endif

    conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .tap1      (tap1),
        .tap2      (tap2),
        .tap3      (tap3),
        .tap4      (tap4),
        .tap5      (tap5),
        .tap6      (tap6),
        .tap7      (tap7),
        .tap8      (tap8),
        .tap9      (tap9),
        .win_valid (win_valid),
        .win_ready (win_ready)
`ifdef CONV_WINDOW_FLAGS_EN
        ,
        .win_eol   (win_eol),
        .win_eof   (win_eof)
`endif
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    n_win = 0;
    win_t  sb_q[$];

    // Reference model: the frame as a 2-D image, windows cut straight out of it.
    logic [DW-1:0] img [IMG_H][IMG_W];
    int            m_row = 0;
    int            m_col = 0;
    bit            m_last_qual = 1'b0;

    bit    rand_ready = 1'b0;
    bit    stall_arm = 1'b0;
    int    stall_left = 0;
    taps_t stall_exp = '0;

    function automatic taps_t act_taps();
        return {tap9, tap8, tap7, tap6, tap5, tap4, tap3, tap2, tap1};
    endfunction

    // Window of a raster image whose pixel (r,c) holds base + r*IMG_W + c.
    function automatic taps_t seq_win(input int base, input int row, input int col);
        taps_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[3*r+c] = DW'(base + (row - 2 + r) * IMG_W + (col - 2 + c));
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_taps(input string name, input taps_t exp);
        n_checks++;
        if (act_taps() !== exp) begin
            n_errors++;
            $display("FAIL %s: got taps %h expected %h", name, act_taps(), exp);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic sof);
        win_t w;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = d;
        m_last_qual = (m_row >= 2) && (m_col >= 2);
        if (m_last_qual) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w.t[3*r+c] = img[m_row-2+r][m_col-2+c];
            w.eol = (m_col == IMG_W - 1);
            w.eof = w.eol && (m_row == IMG_H - 1);
            sb_q.push_back(w);
        end
        m_col++;
        if (m_col == IMG_W) begin
            m_col = 0;
            m_row = (m_row + 1) % IMG_H;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the pixel was taken.
    task automatic send_pixel(input logic [DW-1:0] d, input logic sof);
        int waited;
        waited = 0;
        pix_in = d;
        pix_sof = sof;
        pix_valid = 1'b1;
        #1;
        while (!pix_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!pix_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: pixel 0x%0h not accepted within 200 cycles", d);
            pix_valid = 1'b0;
            @(negedge clk);
            return;
        end
        model_accept(d, sof);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        check("win_valid_latency", win_valid, m_last_qual);
    endtask

    task automatic idle_gap();
        pix_valid = 1'b0;
        pix_in = DW'($urandom);
        pix_sof = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int start, input int expect_win);
        int t;
        t = 0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        while ((sb_q.size() != 0 || win_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("window_count", n_win - start, expect_win);
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic run_seq_frame(input int base, input bit stall);
        int start;
        start = n_win;
        stall_exp = seq_win(base, 2, 2);
        for (int i = 0; i < 16; i++) begin
            if (stall && i == 10) stall_arm = 1'b1;
            send_pixel(DW'(base + i), i == 0);
            if (i == 10) check_taps("first_window", seq_win(base, 2, 2));
            if (i == 11) check_taps("second_window", seq_win(base, 2, 3));
            if (i == 15) begin
                check_taps("last_window", seq_win(base, 3, 3));
`ifdef CONV_WINDOW_FLAGS_EN
                check("last_eol", win_eol, 1);
                check("last_eof", win_eof, 1);
`endif
            end
        end
        drain(start, (IMG_W - 2) * (IMG_H - 2));
    endtask

    task automatic run_random_frames(input int nframes, input bit gaps);
        int start;
        start = n_win;
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < IMG_W * IMG_H; i++) begin
                if (gaps) begin
                    while ($urandom_range(0, 1) == 0) idle_gap();
                end
                send_pixel(DW'($urandom), i == 0);
            end
        end
        drain(start, nframes * (IMG_W - 2) * (IMG_H - 2));
    endtask

    // Downstream ready: steady, random, or a one-shot 5-cycle stall at the next window.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_arm && win_valid) begin
                stall_left = 5;
                stall_arm = 1'b0;
            end
            if (stall_left > 0) begin
                win_ready = 1'b0;
                stall_left--;
                #1;
                check("stall_pix_ready", pix_ready, 0);
                check("stall_win_valid", win_valid, 1);
                check_taps("stall_taps", stall_exp);
            end else begin
                win_ready = rand_ready ? ($urandom_range(0, 9) < 6) : 1'b1;
            end
        end
    end

    // Monitor: the handshake that completes at the coming rising edge.
    initial begin
        win_t  e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && win_valid && win_ready) begin
                n_win++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: window %h with nothing expected", act_taps());
                end else begin
                    e = sb_q.pop_front();
                    if (act_taps() !== e.t) begin
                        n_errors++;
                        $display("FAIL sb_taps: got %h expected %h", act_taps(), e.t);
                    end
`ifdef CONV_WINDOW_FLAGS_EN
                    check("sb_flags", {win_eol, win_eof}, {e.eol, e.eof});
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_win_valid", win_valid, 0);
        check("reset_pix_ready", pix_ready, 1);
        check_taps("reset_taps", '0);
`ifdef CONV_WINDOW_FLAGS_EN
        check("reset_flags", {win_eol, win_eof}, 2'b00);
`endif
        @(negedge clk);

        // Sequential frame, then the same frame with a stall on the first window.
        run_seq_frame(0, 1'b0);
        run_seq_frame(0, 1'b1);

        // sof on the 7th pixel restarts the frame.
        start = n_win;
        for (int i = 0; i < 6; i++) send_pixel(DW'($urandom), i == 0);
        for (int i = 0; i < 16; i++) begin
            send_pixel(DW'($urandom), i == 0);
            if (i == 9)  check("sof_no_win_at_10", win_valid, 0);
            if (i == 10) check("sof_win_at_11", win_valid, 1);
        end
        drain(start, (IMG_W - 2) * (IMG_H - 2));

        // Reset mid-frame after pixel 9, with pix_valid held high during reset.
        for (int i = 0; i < 10; i++) send_pixel(DW'(i), i == 0);
        reset = 1'b1;
        pix_valid = 1'b1;
        pix_in = 16'hdead;
        pix_sof = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pix_valid = 1'b0;
        m_row = 0;
        m_col = 0;
        sb_q.delete();
        #1;
        check("midreset_win_valid", win_valid, 0);
        check("midreset_pix_ready", pix_ready, 1);
        check_taps("midreset_taps", '0);
        @(negedge clk);
        start = n_win;
        for (int i = 0; i < 16; i++) begin
            send_pixel(DW'(100 + i), 1'b0);
            if (i == 10) check_taps("post_reset_first", seq_win(100, 2, 2));
        end
        drain(start, (IMG_W - 2) * (IMG_H - 2));

        // Random data with 50% input gaps, then with random downstream backpressure too.
        run_random_frames(3, 1'b1);
        rand_ready = 1'b1;
        run_random_frames(3, 1'b1);
        rand_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
